dsp_post_adder_acc: RTL and testbench
=====================================

Name: dsp_post_adder_acc

Overview:
Post-adder/subtractor and accumulator stage of the DSP slice. It sits directly downstream of the M-register pipeline stage and the C/D:A:B input pipeline stages.
- Selects X and Z operands through OPMODE-controlled muxes.
- Adds or subtracts them with a carry-in.
- Registers the result in the P register and the carry in the CARRYOUT register.
- Feeds P back for accumulation and drives the PCOUT cascade.

Parameters:
WIDTH_P, 48, width of C, PCIN, P, PCOUT and the D:A:B concatenation.
WIDTH_M, 36, width of the multiplier product input.
PREG, 1, 1 = P output registered; 0 = P combinational.
CARRYOUTREG, 1, 1 = CARRYOUT registered; 0 = combinational.

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  reset, synchronous, active-high; clears the P and CARRYOUT registers
ce_p  input  1  clock enable for the P register
ce_carryout  input  1  clock enable for the CARRYOUT register
opmode_x  input  2  X mux select (OPMODE[1:0])
opmode_z  input  2  Z mux select (OPMODE[3:2])
opmode_sub  input  1  0 = add, 1 = subtract (OPMODE[7])
m_in  input  WIDTH_M  product from the M stage, unsigned
dab_in  input  WIDTH_P  {D[11:0], A[17:0], B[17:0]} from the input stages
c_in  input  WIDTH_P  C operand from the C stage
pcin  input  WIDTH_P  cascade input from the previous slice
carry_in  input  1  carry-in from the CYI stage
p_out  output  WIDTH_P  result
pcout  output  WIDTH_P  cascade output, always equal to p_out
carryout  output  1  carry/borrow out
carryoutf  output  1  fabric copy, always equal to carryout

Behaviour:
- X mux:
  - 00 → 0
  - 01 → m_in zero-extended to WIDTH_P
  - 10 → P feedback
  - 11 → dab_in
- Z mux:
  - 00 → 0
  - 01 → pcin
  - 10 → P feedback
  - 11 → c_in
- P feedback source is the P register output.
  - With PREG=0 there is no register, so selecting P (X=10 or Z=10) yields 0. No combinational loop is permitted.
- Arithmetic is performed in WIDTH_P+1 bits, unsigned.
  - opmode_sub=0: sum = {0,Z} + {0,X} + carry_in
  - opmode_sub=1: sum = {0,Z} − ({0,X} + carry_in)
- Result mapping:
  - p_next = sum[WIDTH_P-1:0]
  - carry_next = sum[WIDTH_P] (carry for add; borrow flag for subtract)
  - Wrap-around is modulo 2^WIDTH_P; there is no saturation.
- PREG=1:
  - Rising edge with rst=1: P ← 0.
  - Otherwise, with ce_p=1: P ← p_next.
  - Otherwise P holds.
  - Latency is 1 cycle from operand/opmode change to p_out.
- PREG=0: p_out = p_next combinationally, with 0 cycles of latency.
- CARRYOUTREG: same rules as PREG, using ce_carryout and carry_next. The P and CARRYOUT enables are independent.
- rst has priority over ce; rst together with ce=1 clears the register.
- Reset mid-accumulation clears P. The next enabled cycle with X=10 or Z=10 accumulates from 0.
- Reset value of every output is 0: p_out, pcout, carryout, carryoutf.
  - This holds for the registered variants. Combinational variants follow their inputs.
- opmode is sampled combinationally in the same cycle as the operands. The opmode registers belong to the upstream stage.

Decomposition:
- Shared package dsp_pkg:
  - X select constants: X_ZERO=2'b00, X_M=2'b01, X_P=2'b10, X_DAB=2'b11.
  - Z select constants: Z_ZERO=2'b00, Z_PCIN=2'b01, Z_P=2'b10, Z_C=2'b11.
  - OP_ADD=0, OP_SUB=1.
  - Width constants for 48 and 36.
- Sub-modules:
  - The P register and CARRYOUT register each use the team's existing Pipeline_Mux register/bypass cell, with RSTTYPE="SYNC".
  - PIPELINE_ENABLE is driven from PREG and CARRYOUTREG respectively.
  - The X/Z mux and adder stay inline in this module.

Test Plan:
1. PREG=1, rst=1 for 2 edges, then rst=0 with ce_p=0 → p_out=0 and carryout=0 throughout.
2. Multiply-add: X=01, Z=11, m_in=36'h0_0000_0064, c_in=48'd5, carry_in=1, add, ce_p=1 → one edge later p_out=48'd106, carryout=0.
3. Accumulate: X=01, Z=10, m_in=10, 4 enabled edges starting from P=0 → p_out 10, 20, 30, 40. Then drop ce_p → p_out holds 40. Then assert rst for 1 edge with ce_p=1 → p_out=0.
4. Wrap and carry: X=11, Z=11, dab_in=c_in=48'hFFFF_FFFF_FFFF, carry_in=0, add → p_out=48'hFFFF_FFFF_FFFE, carryout=1.
5. Subtract with borrow: Z=11 with c_in=3, X=01 with m_in=5, carry_in=0, sub → p_out=48'hFFFF_FFFF_FFFE, carryout=1. With c_in=9 → p_out=4, carryout=0.
6. PREG=0, CARRYOUTREG=0, X=10, Z=01, pcin=7 → p_out=7 with no clock edge (P feedback reads 0). Randomised 100-cycle run against a reference model, checking pcout==p_out and carryoutf==carryout every cycle.

Source files
------------

// File: rtl/dsp_pkg.sv
// Shared constants for the DSP slice: operand mux selects, ALU op codes and datapath widths.
package dsp_pkg;

    localparam int P_WIDTH = 48;
    localparam int M_WIDTH = 36;

    typedef enum logic [1:0] {
        X_ZERO = 2'b00,
        X_M    = 2'b01,
        X_P    = 2'b10,
        X_DAB  = 2'b11
    } x_sel_e;

    typedef enum logic [1:0] {
        Z_ZERO = 2'b00,
        Z_PCIN = 2'b01,
        Z_P    = 2'b10,
        Z_C    = 2'b11
    } z_sel_e;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } alu_op_e;

endpackage

// File: rtl/pipeline_mux.sv
// Register/bypass cell: a clock-enabled register with sync or async active-high reset,
// or a plain wire when PIPELINE_ENABLE is 0.
module pipeline_mux #(
    parameter int    WIDTH           = 1,
    parameter int    PIPELINE_ENABLE = 1,
    parameter string RSTTYPE         = "SYNC"
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        if (PIPELINE_ENABLE != 0) begin : g_reg
            if (RSTTYPE == "ASYNC") begin : g_async
                always_ff @(posedge clk or posedge rst) begin
                    if (rst)     q <= '0;
                    else if (ce) q <= d;
                end
            end else begin : g_sync
                // NOTE: sequential state uses non-blocking assignments so every register
                // samples pre-edge values regardless of process evaluation order.
                always_ff @(posedge clk) begin
                    if (rst)     q <= '0;
                    else if (ce) q <= d;
                end
            end
        end else begin : g_bypass
            logic unused_ctrl;
            assign unused_ctrl = ^{clk, rst, ce};
            assign q = d;
        end
    endgenerate

endmodule

// File: rtl/dsp_post_adder_acc.sv
// Post-adder/subtractor and accumulator: X/Z operand muxes, 49-bit add/sub with carry-in,
// P and CARRYOUT registers (or bypass), P feedback and PCOUT cascade.
module dsp_post_adder_acc
    import dsp_pkg::*;
#(
    parameter int WIDTH_P     = P_WIDTH,
    parameter int WIDTH_M     = M_WIDTH,
    parameter int PREG        = 1,
    parameter int CARRYOUTREG = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ce_p,
    input  logic               ce_carryout,
    input  logic [1:0]         opmode_x,
    input  logic [1:0]         opmode_z,
    input  logic               opmode_sub,
    input  logic [WIDTH_M-1:0] m_in,
    input  logic [WIDTH_P-1:0] dab_in,
    input  logic [WIDTH_P-1:0] c_in,
    input  logic [WIDTH_P-1:0] pcin,
    input  logic               carry_in,
    output logic [WIDTH_P-1:0] p_out,
    output logic [WIDTH_P-1:0] pcout,
    output logic               carryout,
    output logic               carryoutf
);

    logic [WIDTH_P-1:0] p_fb;
    logic [WIDTH_P-1:0] x_mux;
    logic [WIDTH_P-1:0] z_mux;
    logic [WIDTH_P:0]   x_ext;
    logic [WIDTH_P:0]   z_ext;
    logic [WIDTH_P:0]   ci_ext;
    logic [WIDTH_P:0]   sum;
    logic [WIDTH_P-1:0] p_next;
    logic               carry_next;

    // Without a P register there is nothing to feed back; selecting P reads 0 so no loop forms.
    generate
        if (PREG != 0) begin : g_fb
            assign p_fb = p_out;
        end else begin : g_no_fb
            assign p_fb = '0;
        end
    endgenerate

    // NOTE: combinational muxes assign a default first so no path leaves a latch behind.
    always_comb begin
        x_mux = '0;
        case (x_sel_e'(opmode_x))
            X_ZERO: x_mux = '0;
            X_M:    x_mux = {{(WIDTH_P-WIDTH_M){1'b0}}, m_in};
            X_P:    x_mux = p_fb;
            X_DAB:  x_mux = dab_in;
            default: x_mux = '0;
        endcase
    end

    always_comb begin
        z_mux = '0;
        case (z_sel_e'(opmode_z))
            Z_ZERO: z_mux = '0;
            Z_PCIN: z_mux = pcin;
            Z_P:    z_mux = p_fb;
            Z_C:    z_mux = c_in;
            default: z_mux = '0;
        endcase
    end

    assign x_ext  = {1'b0, x_mux};
    assign z_ext  = {1'b0, z_mux};
    assign ci_ext = {{WIDTH_P{1'b0}}, carry_in};

    // Subtract wraps modulo 2^(WIDTH_P+1), so the top bit doubles as the borrow flag.
    always_comb begin
        if (alu_op_e'(opmode_sub) == OP_SUB) sum = z_ext - (x_ext + ci_ext);
        else                                 sum = z_ext + x_ext + ci_ext;
    end

    assign p_next     = sum[WIDTH_P-1:0];
    assign carry_next = sum[WIDTH_P];

    pipeline_mux #(
        .WIDTH           (WIDTH_P),
        .PIPELINE_ENABLE (PREG),
        .RSTTYPE         ("SYNC")
    ) u_p_reg (
        .clk (clk),
        .rst (rst),
        .ce  (ce_p),
        .d   (p_next),
        .q   (p_out)
    );

    pipeline_mux #(
        .WIDTH           (1),
        .PIPELINE_ENABLE (CARRYOUTREG),
        .RSTTYPE         ("SYNC")
    ) u_carryout_reg (
        .clk (clk),
        .rst (rst),
        .ce  (ce_carryout),
        .d   (carry_next),
        .q   (carryout)
    );

    assign pcout     = p_out;
    assign carryoutf = carryout;

endmodule

// File: tb/tb_dsp_post_adder_acc.sv
// Self-checking bench: a registered slice and a fully combinational slice share one stimulus
// stream and are compared against constants and an arithmetic reference model.
module tb_dsp_post_adder_acc;

    logic        clk;
    logic        rst;
    logic        ce_p;
    logic        ce_carryout;
    logic [1:0]  opmode_x;
    logic [1:0]  opmode_z;
    logic        opmode_sub;
    logic [35:0] m_in;
    logic [47:0] dab_in;
    logic [47:0] c_in;
    logic [47:0] pcin;
    logic        carry_in;

    logic [47:0] p_reg, pcout_reg;
    logic        co_reg, cof_reg;
    logic [47:0] p_comb, pcout_comb;
    logic        co_comb, cof_comb;

    int n_checks = 0;
    int n_fail   = 0;

    logic [47:0] p_model;
    logic        c_model;

    dsp_post_adder_acc #(.PREG(1), .CARRYOUTREG(1)) dut_reg (
        .clk         (clk),
        .rst         (rst),
        .ce_p        (ce_p),
        .ce_carryout (ce_carryout),
        .opmode_x    (opmode_x),
        .opmode_z    (opmode_z),
        .opmode_sub  (opmode_sub),
        .m_in        (m_in),
        .dab_in      (dab_in),
        .c_in        (c_in),
        .pcin        (pcin),
        .carry_in    (carry_in),
        .p_out       (p_reg),
        .pcout       (pcout_reg),
        .carryout    (co_reg),
        .carryoutf   (cof_reg)
    );

    dsp_post_adder_acc #(.PREG(0), .CARRYOUTREG(0)) dut_comb (
        .clk         (clk),
        .rst         (rst),
        .ce_p        (ce_p),
        .ce_carryout (ce_carryout),
        .opmode_x    (opmode_x),
        .opmode_z    (opmode_z),
        .opmode_sub  (opmode_sub),
        .m_in        (m_in),
        .dab_in      (dab_in),
        .c_in        (c_in),
        .pcin        (pcin),
        .carry_in    (carry_in),
        .p_out       (p_comb),
        .pcout       (pcout_comb),
        .carryout    (co_comb),
        .carryoutf   (cof_comb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        string       name;
        logic [1:0]  ox;
        logic [1:0]  oz;
        logic        sb;
        logic [35:0] m;
        logic [47:0] dab;
        logic [47:0] c;
        logic [47:0] pc;
        logic        ci;
        logic [47:0] exp_p;
        logic        exp_co;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: unsigned 49-bit add/sub computed with plain integer arithmetic.
    function automatic logic [48:0] ref_sum(input logic [47:0] pfb);
        longint unsigned xv, zv, r;
        case (opmode_x)
            2'b00:   xv = 0;
            2'b01:   xv = longint'(m_in);
            2'b10:   xv = longint'(pfb);
            default: xv = longint'(dab_in);
        endcase
        case (opmode_z)
            2'b00:   zv = 0;
            2'b01:   zv = longint'(pcin);
            2'b10:   zv = longint'(pfb);
            default: zv = longint'(c_in);
        endcase
        if (opmode_sub) r = zv - (xv + longint'(carry_in));
        else            r = zv + xv + longint'(carry_in);
        return r[48:0];
    endfunction

    // One rising edge; the model follows the register rules and outputs are sampled 1 ns later.
    task automatic tick();
        logic [48:0] r;
        r = ref_sum(p_model);
        @(posedge clk);
        if (rst) begin
            p_model = '0;
            c_model = 1'b0;
        end else begin
            if (ce_p)        p_model = r[47:0];
            if (ce_carryout) c_model = r[48];
        end
        #1;
    endtask

    task automatic apply_vec(input vec_t v);
        opmode_x   = v.ox;
        opmode_z   = v.oz;
        opmode_sub = v.sb;
        m_in       = v.m;
        dab_in     = v.dab;
        c_in       = v.c;
        pcin       = v.pc;
        carry_in   = v.ci;
    endtask

    task automatic check_cascade(input string tag);
        check({tag, " pcout_reg"},  pcout_reg,  p_reg);
        check({tag, " cof_reg"},    cof_reg,    co_reg);
        check({tag, " pcout_comb"}, pcout_comb, p_comb);
        check({tag, " cof_comb"},   cof_comb,   co_comb);
    endtask

    initial begin
        logic [48:0] r;

        vecs[0] = '{"mult_add",    2'b01, 2'b11, 1'b0, 36'h0_0000_0064, 48'd0,
                    48'd5, 48'd0, 1'b1, 48'd106, 1'b0};
        vecs[1] = '{"wrap_carry",  2'b11, 2'b11, 1'b0, 36'd0, 48'hFFFF_FFFF_FFFF,
                    48'hFFFF_FFFF_FFFF, 48'd0, 1'b0, 48'hFFFF_FFFF_FFFE, 1'b1};
        vecs[2] = '{"sub_borrow",  2'b01, 2'b11, 1'b1, 36'd5, 48'd0,
                    48'd3, 48'd0, 1'b0, 48'hFFFF_FFFF_FFFE, 1'b1};
        vecs[3] = '{"sub_noborrow", 2'b01, 2'b11, 1'b1, 36'd5, 48'd0,
                    48'd9, 48'd0, 1'b0, 48'd4, 1'b0};
        vecs[4] = '{"pcin_pass",   2'b00, 2'b01, 1'b0, 36'd0, 48'd0,
                    48'd0, 48'h1234_5678_9ABC, 1'b0, 48'h1234_5678_9ABC, 1'b0};

        p_model     = '0;
        c_model     = 1'b0;
        rst         = 1'b1;
        ce_p        = 1'b0;
        ce_carryout = 1'b0;
        apply_vec(vecs[0]);

        // Reset for two edges, then idle with enables low.
        for (int i = 0; i < 2; i++) begin
            tick();
            check("reset p_out", p_reg, 48'd0);
            check("reset carryout", co_reg, 1'b0);
        end
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("idle p_out", p_reg, 48'd0);
            check("idle carryout", co_reg, 1'b0);
        end
        check_cascade("idle");

        // Table vectors: combinational slice before the edge, registered slice after it.
        ce_p        = 1'b1;
        ce_carryout = 1'b1;
        for (int i = 0; i < 5; i++) begin
            apply_vec(vecs[i]);
            #1;
            check({vecs[i].name, " comb p"},  p_comb,  vecs[i].exp_p);
            check({vecs[i].name, " comb co"}, co_comb, vecs[i].exp_co);
            tick();
            check({vecs[i].name, " reg p"},  p_reg,  vecs[i].exp_p);
            check({vecs[i].name, " reg co"}, co_reg, vecs[i].exp_co);
            check_cascade(vecs[i].name);
        end

        // Independent enables: carry-only update, then P-only update.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        apply_vec(vecs[1]);
        ce_p        = 1'b0;
        ce_carryout = 1'b1;
        tick();
        check("ce_co only p", p_reg, 48'd0);
        check("ce_co only co", co_reg, 1'b1);
        apply_vec(vecs[3]);
        ce_p        = 1'b1;
        ce_carryout = 1'b0;
        tick();
        check("ce_p only p", p_reg, 48'd4);
        check("ce_p only co", co_reg, 1'b1);

        // Reset with enables high clears both registers.
        ce_carryout = 1'b1;
        rst = 1'b1;
        tick();
        check("rst over ce p", p_reg, 48'd0);
        check("rst over ce co", co_reg, 1'b0);
        rst = 1'b0;

        // Accumulate 10 per edge, hold, reset mid-accumulation, resume from 0.
        opmode_x   = 2'b01;
        opmode_z   = 2'b10;
        opmode_sub = 1'b0;
        m_in       = 36'd10;
        carry_in   = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            check("accumulate", p_reg, 48'(10 * i));
        end
        ce_p = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("accumulate hold", p_reg, 48'd40);
        end
        ce_p = 1'b1;
        rst  = 1'b1;
        tick();
        check("accumulate reset", p_reg, 48'd0);
        rst = 1'b0;
        tick();
        check("accumulate restart", p_reg, 48'd10);

        // Combinational slice: P feedback reads 0, so X=P contributes nothing.
        opmode_x   = 2'b10;
        opmode_z   = 2'b01;
        opmode_sub = 1'b0;
        pcin       = 48'd7;
        carry_in   = 1'b0;
        #1;
        check("comb no-edge p", p_comb, 48'd7);
        check("comb no-edge co", co_comb, 1'b0);
        opmode_z = 2'b10;
        opmode_x = 2'b11;
        dab_in   = 48'd33;
        #1;
        check("comb z=p reads 0", p_comb, 48'd33);

        // Randomised run against the reference model on both slices.
        for (int i = 0; i < 100; i++) begin
            rst         = ($urandom_range(0, 15) == 0);
            ce_p        = ($urandom_range(0, 3) != 0);
            ce_carryout = ($urandom_range(0, 3) != 0);
            opmode_x    = 2'($urandom_range(0, 3));
            opmode_z    = 2'($urandom_range(0, 3));
            opmode_sub  = 1'($urandom_range(0, 1));
            m_in        = {4'($urandom), 32'($urandom)};
            dab_in      = ($urandom_range(0, 7) == 0) ? 48'hFFFF_FFFF_FFFF : {16'($urandom), 32'($urandom)};
            c_in        = ($urandom_range(0, 7) == 0) ? 48'hFFFF_FFFF_FFFF : {16'($urandom), 32'($urandom)};
            pcin        = {16'($urandom), 32'($urandom)};
            carry_in    = 1'($urandom_range(0, 1));
            #1;
            r = ref_sum(48'd0);
            check("rand comb p", p_comb, r[47:0]);
            check("rand comb co", co_comb, r[48]);
            tick();
            check("rand reg p", p_reg, p_model);
            check("rand reg co", co_reg, c_model);
            check_cascade("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
